ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Synthesizable configuration-chain driver for the FPGA fabric. It shifts a bitstream into NUM_CHAINS parallel configuration chains (ccff) from a valid/ready bit source. In integrity-test mode it pushes a single marker pulse through every chain and checks that each ccff_tail emits it at exactly CHAIN_LEN shifts. It sits between the SoC-side bitstream source and the fabric's ccff_head/ccff_tail pins, and replaces the single-chain, fixed-length, testbench-only pulse check.

## Interface
- NUM_CHAINS, 4, number of parallel chains; one bit per chain per beat
- CHAIN_LEN, 7424, flip-flops per chain (29696 / 4)
- CNT_W, 14, counter width; must satisfy 2^CNT_W > CHAIN_LEN+2
- prog_clk  in  1  programming clock; single clock domain
- prog_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; ignored unless IDLE
- mode  in  1  sampled with start: 0 = program, 1 = integrity test
- bs_valid  in  1  bitstream beat valid
- bs_ready  out  1  beat accepted when bs_valid && bs_ready
- bs_data  in  NUM_CHAINS  bit i goes to chain i
- ccff_head  out  NUM_CHAINS  registered chain data
- ccff_shift_en  out  1  registered; fabric chains shift on the prog_clk rising edge when high
- ccff_tail  in  NUM_CHAINS  last flip-flop of each chain
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse at end of run
- error  out  1  |err_chain; valid while done is high, held until next start
- err_chain  out  NUM_CHAINS  per-chain failure mask, sticky until next start
- bit_count  out  CNT_W  shift cycles issued in current run

## Operation
- States: IDLE, LOAD, TEST, FIN.
- Shift cycle n is the n-th cycle, counting from 0, in which ccff_shift_en = 1.
- IDLE, start=1, mode=0: go to LOAD and clear err_chain and bit_count.
- LOAD:
  - bs_ready = 1 until CHAIN_LEN beats have been accepted.
  - Each accepted beat registers head <= bs_data and shift_en <= 1.
  - Cycles without an accepted beat register shift_en <= 0 and hold head.
  - After the CHAIN_LEN-th acceptance: bs_ready drops, then go to FIN.
  - The first accepted beat ends up in the tail flip-flop.
- IDLE, start=1, mode=1: go to TEST and clear err_chain and bit_count.
- TEST:
  - shift_en = 1 for exactly CHAIN_LEN+2 consecutive cycles.
  - head = all-ones on shift cycle 0 and all-zeros after that.
  - ccff_tail is sampled at the closing edge of shift cycle CHAIN_LEN; it must be all-ones.
  - ccff_tail is sampled at the closing edge of shift cycle CHAIN_LEN+1; it must be all-zeros.
  - Any mismatch, including X/Z, sets the corresponding err_chain bit.
  - Tail values are not checked in earlier cycles.
  - bs_ready = 0 throughout.
- FIN: shift_en = 0, head = 0, done = 1 for one cycle, then IDLE.
- In program mode error is always 0.
- bit_count increments once per shift cycle and saturates at 2^CNT_W-1.
- Program mode with CHAIN_LEN accepted beats never exceeds the counter range.

## Timing
- Reset values (while prog_reset is high, and on the following cycle):
  - ccff_head = 0, ccff_shift_en = 0, bs_ready = 0
  - busy = 0, done = 0, error = 0, err_chain = 0, bit_count = 0
  - state = IDLE
- Start latency: start sampled at edge E0 means busy = 1 from the cycle after E0.
- LOAD: bs_ready = 1 in the first LOAD cycle. A beat accepted at edge E appears on ccff_head with shift_en = 1 in the cycle after E; the chain captures it at the next edge.
- TEST: shift cycle 0 is the cycle immediately after E0. done is high in cycle CHAIN_LEN+3, counting the cycle after E0 as cycle 1.
- Program mode with bs_valid held high: done is high in cycle CHAIN_LEN+2.
- start while busy is ignored and mode is not re-sampled.
- prog_reset mid-run: reset wins over everything, including a simultaneous start. The state returns to IDLE, no done pulse is issued, and outputs go to reset values. Chain contents are undefined.
- start in the FIN cycle is ignored; start in the cycle after FIN is accepted.

## Test plan
All scenarios use NUM_CHAINS=4, CHAIN_LEN=8, CNT_W=4 and a behavioural chain model (shift on edge when shift_en = 1).
1. Reset: assert prog_reset for 3 cycles with start=1 -> all outputs 0, busy stays 0 one cycle after release.
2. Program, bs_valid always high, beats 4'h1..4'h8 -> 8 contiguous shift cycles, bs_ready drops after the 8th acceptance, done in cycle 10, tail flip-flop holds 4'h1 and head flip-flop holds 4'h8, error=0, bit_count=8.
3. Program with bs_valid toggling 1,0,0,1,... -> shift_en is low during every gap, exactly 8 shift cycles, chain contents identical to scenario 2.
4. Test mode, all chains length 8 -> shift_en high for 10 cycles, head=4'hF only in cycle 1, done in cycle 11, err_chain=0, error=0.
5. Test mode, model chain 2 as length 9 and chain 0 tail forced X -> err_chain=4'b0101, error=1, held until the next start, then cleared.
6. Program, assert prog_reset after 5 accepted beats -> immediate IDLE, no done. Then start while busy in a fresh run -> ignored. A fresh start (mode=1) after FIN -> completes as in scenario 4.

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: bitstream handshake and fabric ccff pins
interface ccff_chain_loader_if #(
  parameter int NUM_CHAINS = 4
);
  logic                  bs_valid;
  logic                  bs_ready;
  logic [NUM_CHAINS-1:0] bs_data;
  logic [NUM_CHAINS-1:0] ccff_head;
  logic                  ccff_shift_en;
  logic [NUM_CHAINS-1:0] ccff_tail;
  modport master (input bs_valid, bs_data, ccff_tail, output bs_ready, ccff_head, ccff_shift_en);
  modport slave (output bs_valid, bs_data, ccff_tail, input bs_ready, ccff_head, ccff_shift_en);
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: shifts a bitstream into parallel ccff chains or runs a marker-pulse integrity test
module ccff_chain_loader #(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 7424,
  parameter int CNT_W      = 14
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic                  mode,
  ccff_chain_loader_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [NUM_CHAINS-1:0] err_chain,
  output logic [CNT_W-1:0]      bit_count
);
  localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN1 = CNT_W'(CHAIN_LEN + 1);
  typedef enum logic [1:0] {IDLE, LOAD, TEST, FIN} state_t;
  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n, bit_count_n;
  logic [NUM_CHAINS-1:0] head, head_n, err_n;
  logic                  shift_en, shift_n, accept;
  assign bus.bs_ready      = state == LOAD && cnt != LEN;
  assign bus.ccff_head     = head;
  assign bus.ccff_shift_en = shift_en;
  assign accept            = bus.bs_valid && bus.bs_ready;
  assign busy              = state != IDLE;
  assign done              = state == FIN;
  assign error             = |err_chain;
  // state, chain drive and result registers
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      head      <= '0;
      shift_en  <= 1'b0;
      err_chain <= '0;
      bit_count <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      head      <= head_n;
      shift_en  <= shift_n;
      err_chain <= err_n;
      bit_count <= bit_count_n;
    end
  end
  // next state: cnt counts accepted beats in LOAD and the current shift cycle in TEST
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    head_n      = head;
    shift_n     = 1'b0;
    err_n       = err_chain;
    bit_count_n = bit_count + CNT_W'(shift_en && bit_count != '1);
    case (state)
      IDLE: if (start) begin
        state_n     = mode ? TEST : LOAD;
        cnt_n       = '0;
        err_n       = '0;
        bit_count_n = '0;
        shift_n     = mode;
        head_n      = {NUM_CHAINS{mode}};
      end
      LOAD: if (accept) begin
        head_n  = bus.bs_data;
        shift_n = 1'b1;
        cnt_n   = cnt + CNT_W'(1);
      end else if (cnt == LEN) begin
        head_n  = '0;
        state_n = FIN;
      end
      TEST: begin
        head_n  = '0;
        shift_n = cnt != LEN1;
        cnt_n   = cnt + CNT_W'(1);
        for (int i = 0; i < NUM_CHAINS; i++)
          if ((cnt == LEN && bus.ccff_tail[i] !== 1'b1) || (cnt == LEN1 && bus.ccff_tail[i] !== 1'b0))
            err_n[i] = 1'b1;
        state_n = cnt == LEN1 ? FIN : TEST;
      end
      default: begin
        head_n  = '0;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: scoreboard bench with a behavioural fabric chain model
module tb_ccff_chain_loader;
  localparam int N = 4;
  localparam int L = 8;
  localparam int W = 4;
  typedef struct packed {
    logic [N-1:0]        err;
    logic                eflag;
    logic [W-1:0]        bc;
    logic [7:0]          dc;
    logic                prog;
    logic [L-1:0][N-1:0] beats;
  } exp_t;
  logic prog_clk = 1'b0, prog_reset = 1'b1, start = 1'b1, mode = 1'b0;
  logic busy, done, error;
  logic [N-1:0] err_chain;
  logic [W-1:0] bit_count;
  ccff_chain_loader_if #(.NUM_CHAINS(N)) bus ();
  ccff_chain_loader #(.NUM_CHAINS(N), .CHAIN_LEN(L), .CNT_W(W)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .mode(mode), .bus(bus),
    .busy(busy), .done(done), .error(error), .err_chain(err_chain), .bit_count(bit_count)
  );
  always #5 prog_clk = ~prog_clk;
  int nchk = 0, npass = 0, rel = 0, nacc = 0;
  exp_t q[$];
  bit prog_chk = 0, test_chk = 0, pacc = 0;
  logic [N-1:0] pdata;
  logic chain [N][16];
  int lens [N] = '{L, L, L, L};
  logic [N-1:0] xt = '0;
  // fabric: each chain shifts toward its tail on shift-enabled edges; tail taps position lens-1
  always @(posedge prog_clk)
    if (bus.ccff_shift_en)
      for (int i = 0; i < N; i++) begin
        for (int j = 15; j > 0; j--) chain[i][j] <= chain[i][j-1];
        chain[i][0] <= bus.ccff_head[i];
      end
  always_comb begin
    bus.ccff_tail = '0;
    for (int i = 0; i < N; i++) bus.ccff_tail[i] = xt[i] ? 1'bx : chain[i][lens[i]-1];
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask
  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask
  function automatic logic [16:0] outs();
    return {bus.ccff_head, bus.ccff_shift_en, bus.bs_ready, busy, done, error, err_chain, bit_count};
  endfunction
  // monitor: per-cycle protocol checks and scoreboard pop on done
  always @(negedge prog_clk) begin
    exp_t e;
    logic [N-1:0] got;
    if (prog_reset || (start && !busy)) begin
      rel = 0;
      nacc = 0;
    end else rel++;
    if (prog_chk && busy) begin
      chk("shift_en_load", bus.ccff_shift_en, pacc);
      if (pacc) chk("head_load", bus.ccff_head, pdata);
      chk("bs_ready_load", bus.bs_ready, nacc < L && !done);
    end
    if (test_chk && rel >= 1 && rel <= L + 3) begin
      chk("shift_en_test", bus.ccff_shift_en, rel <= L + 2);
      chk("head_test", bus.ccff_head, rel == 1 ? 4'hF : 4'h0);
      chk("bs_ready_test", bus.bs_ready, 0);
    end
    pacc = bus.bs_valid && bus.bs_ready;
    pdata = bus.bs_data;
    if (pacc) nacc++;
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", done, 0);
      else begin
        e = q.pop_front();
        chk("err_chain", err_chain, e.err);
        chk("error", error, e.eflag);
        chk("bit_count", bit_count, e.bc);
        if (e.dc != 0) chk("done_cycle", rel, e.dc);
        if (e.prog)
          for (int k = 0; k < L; k++) begin
            for (int i = 0; i < N; i++) got[i] = chain[i][L-1-k];
            chk("chain_pos", got, e.beats[k]);
          end
      end
    end
  end
  task automatic wait_done;
    for (int i = 0; i < 60 && q.size() != 0; i++) tick;
    chk("done_timeout", q.size(), 0);
    q.delete();
    prog_chk = 0;
    test_chk = 0;
  endtask
  task automatic push_prog(input logic [L-1:0][N-1:0] b, input logic [7:0] dc);
    exp_t e;
    e.err = '0; e.eflag = 1'b0; e.bc = W'(L); e.dc = dc; e.prog = 1'b1; e.beats = b;
    q.push_back(e);
  endtask
  task automatic push_test;
    exp_t e;
    for (int i = 0; i < N; i++) e.err[i] = lens[i] != L || xt[i];
    e.eflag = |e.err; e.bc = W'(L + 2); e.dc = 8'(L + 3); e.prog = 1'b0; e.beats = '0;
    q.push_back(e);
  endtask
  task automatic prog_run(input logic [L-1:0][N-1:0] b, input logic [31:0] vpat);
    int n = 0, dc = 0, idx = 0;
    for (int k = 1; k <= 32; k++)
      if (vpat[k-1]) begin
        n++;
        if (n == L) dc = k + 2;
      end
    push_prog(b, 8'(dc));
    prog_chk = 1;
    start = 1; mode = 0;
    tick;
    start = 0;
    chk("busy_latency", busy, 1);
    chk("err_clear", err_chain, 0);
    for (int k = 1; k <= 32 && idx < L; k++) begin
      bus.bs_valid = vpat[k-1];
      bus.bs_data = b[idx];
      tick;
      if (vpat[k-1]) idx++;
    end
    bus.bs_valid = 0;
    bus.bs_data = '0;
    wait_done;
  endtask
  task automatic test_run;
    push_test;
    test_chk = 1;
    start = 1; mode = 1;
    tick;
    start = 0;
    wait_done;
  endtask
  function automatic logic [L-1:0][N-1:0] rnd_beats();
    logic [L-1:0][N-1:0] b;
    for (int k = 0; k < L; k++) b[k] = N'($urandom);
    return b;
  endfunction
  initial begin
    logic [L-1:0][N-1:0] b;
    logic [31:0] vp;
    bus.bs_valid = 0;
    bus.bs_data = '0;
    repeat (3) tick;
    chk("reset_outs", outs(), 0);
    prog_reset = 0; start = 0;
    tick;
    chk("post_reset_outs", outs(), 0);
    for (int k = 0; k < L; k++) b[k] = N'(k + 1);
    prog_run(b, 32'hFFFF_FFFF);
    vp = '0;
    for (int k = 0; k < 32; k++) vp[k] = k % 3 == 0;
    prog_run(b, vp);
    test_run;
    lens[2] = 9; xt[0] = 1;
    test_run;
    repeat (3) tick;
    chk("error_held", error, 1);
    chk("err_chain_held", err_chain, 4'b0101);
    lens[2] = L; xt = '0;
    prog_run(rnd_beats(), $urandom | 32'h1111_1111);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) lens[i] = $urandom_range(0, 3) == 0 ? $urandom_range(L - 1, L + 1) : L;
      xt = N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      test_run;
    end
    for (int i = 0; i < N; i++) lens[i] = L;
    xt = '0;
    prog_run(rnd_beats(), $urandom | 32'h2222_2222);
    start = 1; mode = 0;
    tick;
    start = 0;
    for (int k = 1; k <= 5; k++) begin
      bus.bs_valid = 1;
      bus.bs_data = N'($urandom);
      tick;
    end
    prog_reset = 1; start = 1; mode = 1;
    tick;
    chk("mid_reset_outs", outs(), 0);
    prog_reset = 0; start = 0; bus.bs_valid = 0;
    tick;
    chk("mid_reset_busy", busy, 0);
    repeat (14) tick;
    b = rnd_beats();
    push_prog(b, 8'(L + 2));
    prog_chk = 1;
    start = 1; mode = 0;
    tick;
    for (int k = 1; k <= L; k++) begin
      start = k == 4;
      mode = 1;
      bus.bs_valid = 1;
      bus.bs_data = b[k-1];
      tick;
    end
    start = 0;
    bus.bs_valid = 0;
    bus.bs_data = '0;
    tick;
    push_test;
    start = 1; mode = 1;
    tick;
    prog_chk = 0;
    test_chk = 1;
    tick;
    start = 0;
    wait_done;
    repeat (5) tick;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
